// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared ULA select codes, op classes, funct codes and muldiv FSM states
package ula_pkg;

  // ULA select codes driven onto operation
  localparam logic [3:0] SEL_AND   = 4'b0000;
  localparam logic [3:0] SEL_OR    = 4'b0001;
  localparam logic [3:0] SEL_ADD   = 4'b0010;
  localparam logic [3:0] SEL_SLL   = 4'b0011;
  localparam logic [3:0] SEL_SRA   = 4'b0100;
  localparam logic [3:0] SEL_SRL   = 4'b0101;
  localparam logic [3:0] SEL_SUB   = 4'b0110;
  localparam logic [3:0] SEL_SLT   = 4'b0111;
  localparam logic [3:0] SEL_LUI   = 4'b1000;
  localparam logic [3:0] SEL_SRAV  = 4'b1010;
  localparam logic [3:0] SEL_CMPNE = 4'b1011;
  localparam logic [3:0] SEL_NOR   = 4'b1100;
  localparam logic [3:0] SEL_XOR   = 4'b1101;
  localparam logic [3:0] SEL_SLLV  = 4'b1110;
  localparam logic [3:0] SEL_SRLV  = 4'b1111;

  // main-control op classes
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_RTYPE = 4'b0010;
  localparam logic [3:0] OP_SLT   = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_XOR   = 4'b0110;
  localparam logic [3:0] OP_CMPNE = 4'b0111;
  localparam logic [3:0] OP_LUI   = 4'b1000;

  // R-type funct codes
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  // true for the eight funct codes owned by the HI/LO unit
  function automatic logic is_muldiv_func(input logic [5:0] f);
    return (f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU});
  endfunction

endpackage

// File: rtl/ula_op_decode.sv
// rtl/ula_op_decode.sv - combinational ula_operation/func to ULA select table
module ula_op_decode
  import ula_pkg::*;
(
  input  logic [3:0] ula_operation_i,
  input  logic [5:0] func_i,
  output logic [3:0] operation_o
);

  // op class picks the select directly; R-type defers to funct; muldiv functs fall to AND
  always_comb begin
    operation_o = SEL_AND;
    case (ula_operation_i)
      OP_ADD:   operation_o = SEL_ADD;
      OP_SUB:   operation_o = SEL_SUB;
      OP_SLT:   operation_o = SEL_SLT;
      OP_LUI:   operation_o = SEL_LUI;
      OP_AND:   operation_o = SEL_AND;
      OP_OR:    operation_o = SEL_OR;
      OP_XOR:   operation_o = SEL_XOR;
      OP_CMPNE: operation_o = SEL_CMPNE;
      OP_RTYPE: begin
        case (func_i)
          F_SLLV:         operation_o = SEL_SLLV;
          F_SRLV:         operation_o = SEL_SRLV;
          F_SRAV:         operation_o = SEL_SRAV;
          F_SRA:          operation_o = SEL_SRA;
          F_SRL:          operation_o = SEL_SRL;
          F_SLL:          operation_o = SEL_SLL;
          F_ADD:          operation_o = SEL_ADD;
          F_SUB:          operation_o = SEL_SUB;
          F_AND:          operation_o = SEL_AND;
          F_OR:           operation_o = SEL_OR;
          F_XOR:          operation_o = SEL_XOR;
          F_NOR:          operation_o = SEL_NOR;
          F_SLT, F_SLTU:  operation_o = SEL_SLT;
          default:        operation_o = SEL_AND;
        endcase
      end
      default:  operation_o = SEL_AND;
    endcase
  end

endmodule

// File: rtl/ula_muldiv_unit.sv
// rtl/ula_muldiv_unit.sv - ULA select decode plus multi-cycle MULT/DIV engine with HI/LO
module ula_muldiv_unit
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ula_operation,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       operation,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  md_state_e        state_q, state_d;
  logic [CW-1:0]    counter_q;
  logic [W2-1:0]    acc_q;      // mul: running product; div: {remainder, dividend/quotient}
  logic [W2-1:0]    mcd_q;      // mul: multiplicand shifted left each step; div: divisor in low half
  logic [WIDTH-1:0] mpl_q;      // mul: multiplier shifted right each step
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             is_div_q, neg_q, neg_rem_q, dz_q;

  logic             md_func, accept, start_eng, signed_op, is_div_f, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   div_tmp, div_diff;
  logic [W2-1:0]    acc_step, prod_fix;
  logic [WIDTH-1:0] quo, rem, hi_fix, lo_fix;

  ula_op_decode u_decode (
    .ula_operation_i (ula_operation),
    .func_i          (func),
    .operation_o     (operation)
  );

  assign md_func   = (ula_operation == OP_RTYPE) && is_muldiv_func(func);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FIX);
  assign div_zero  = done & dz_q;
  assign accept    = start & md_func & ~busy;
  assign stall     = start & md_func & busy;
  assign start_eng = accept && (func inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
  assign hi        = hi_q;
  assign lo        = lo_q;

  // within the MULT/DIV group bit0 marks the unsigned form and bit1 marks divide
  assign signed_op = ~func[0];
  assign is_div_f  = func[1];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // MFHI/MFLO read straight from the registers in the accepting cycle
  always_comb begin
    result = '0;
    if (accept && func == F_MFHI) result = hi_q;
    else if (accept && func == F_MFLO) result = lo_q;
  end

  // one iteration: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    div_tmp  = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_tmp - {1'b0, mcd_q[WIDTH-1:0]};
    acc_step = acc_q + (mpl_q[0] ? mcd_q : '0);
    if (is_div_q) begin
      if (div_diff[WIDTH]) acc_step = {div_tmp[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else                 acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  // sign fixup; a zero divisor leaves rem=|a| so the signed remainder fixup restores a
  always_comb begin
    quo      = acc_q[WIDTH-1:0];
    rem      = acc_q[W2-1:WIDTH];
    prod_fix = neg_q ? -acc_q : acc_q;
    hi_fix   = prod_fix[W2-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      hi_fix = neg_rem_q ? -rem : rem;
      lo_fix = dz_q ? '1 : (neg_q ? -quo : quo);
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: WIDTH RUN steps then one FIX cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_eng) state_d = ST_RUN;
      ST_RUN:  if (counter_q == '0) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // datapath: operand latch, iteration, HI/LO write-back and MTHI/MTLO
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter_q <= '0;
      acc_q     <= '0;
      mcd_q     <= '0;
      mpl_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && func == F_MTHI) hi_q <= a;
          if (accept && func == F_MTLO) lo_q <= a;
          if (start_eng) begin
            counter_q <= CW'(WIDTH - 1);
            is_div_q  <= is_div_f;
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dz_q      <= is_div_f && (b == '0);
            mpl_q     <= b_mag;
            if (is_div_f) begin
              acc_q <= {{WIDTH{1'b0}}, a_mag};
              mcd_q <= {{WIDTH{1'b0}}, b_mag};
            end else begin
              acc_q <= '0;
              mcd_q <= {{WIDTH{1'b0}}, a_mag};
            end
          end
        end
        ST_RUN: begin
          acc_q <= acc_step;
          mpl_q <= mpl_q >> 1;
          if (!is_div_q) mcd_q <= mcd_q << 1;
          if (counter_q != '0) counter_q <= counter_q - 1'b1;
        end
        ST_FIX: begin
          hi_q <= hi_fix;
          lo_q <= lo_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_muldiv_unit.sv
// tb/tb_ula_muldiv_unit.sv - self-checking bench for ula_muldiv_unit against an arithmetic model
module tb_ula_muldiv_unit;

  localparam int W = 32;
  localparam logic [3:0] OPR   = 4'b0010;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MTLO  = 6'b010011;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;

  logic          clock, reset, start;
  logic [3:0]    ula_operation;
  logic [5:0]    func;
  logic [W-1:0]  a, b;
  logic [3:0]    operation;
  logic [W-1:0]  result, hi, lo;
  logic          busy, done, div_zero, stall;

  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  exp_hi = '0;
  logic [W-1:0]  exp_lo = '0;

  ula_muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .ula_operation(ula_operation),
    .func(func), .a(a), .b(b), .operation(operation), .result(result),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero), .stall(stall)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // reference: plain 64-bit arithmetic; SV / and % truncate toward zero
  task automatic ref_md(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] eh, output logic [31:0] el, output logic ez);
    longint sx, sy, sp, sq, sr;
    longint unsigned up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ez = 1'b0;
    if ((f == DIV || f == DIVU) && y == 0) begin
      eh = x; el = '1; ez = 1'b1;
    end else if (f == MULT) begin
      sp = sx * sy; eh = sp[63:32]; el = sp[31:0];
    end else if (f == MULTU) begin
      up = {32'b0, x} * {32'b0, y}; eh = up[63:32]; el = up[31:0];
    end else if (f == DIV) begin
      sq = sx / sy; sr = sx % sy; el = sq[31:0]; eh = sr[31:0];
    end else begin
      el = x / y; eh = x % y;
    end
  endtask

  function automatic logic [3:0] ref_op(input logic [3:0] op, input logic [5:0] f);
    case (op)
      4'b0000: return 4'b0010;
      4'b0001: return 4'b0110;
      4'b0011: return 4'b0111;
      4'b1000: return 4'b1000;
      4'b0100: return 4'b0000;
      4'b0101: return 4'b0001;
      4'b0110: return 4'b1101;
      4'b0111: return 4'b1011;
      4'b0010: begin
        case (f)
          6'b000100: return 4'b1110;
          6'b000110: return 4'b1111;
          6'b000111: return 4'b1010;
          6'b000011: return 4'b0100;
          6'b000010: return 4'b0101;
          6'b000000: return 4'b0011;
          6'b100000: return 4'b0010;
          6'b100010: return 4'b0110;
          6'b100100: return 4'b0000;
          6'b100101: return 4'b0001;
          6'b100110: return 4'b1101;
          6'b100111: return 4'b1100;
          6'b101010, 6'b101011: return 4'b0111;
          default: return 4'b0000;
        endcase
      end
      default: return 4'b0000;
    endcase
  endfunction

  // issue one MULT*/DIV* at posedge+1 of cycle 0; returns at posedge+1 of cycle W+2
  task automatic run_md(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y, input bit hold_mf);
    logic [31:0] eh, el;
    logic ez, dz_seen;
    int cyc, done_cyc;
    bit busy_ok, stall_ok, hl_ok;
    ref_md(f, x, y, eh, el, ez);
    ula_operation = OPR; func = f; a = x; b = y; start = 1'b1;
    @(negedge clock);
    chk("accept_stall", stall, 0);
    chk("accept_busy", busy, 0);
    @(posedge clock); #1;
    start = hold_mf; func = hold_mf ? MFLO : 6'b000000;
    a = $urandom; b = $urandom;
    cyc = 1; done_cyc = -1; dz_seen = 1'b0; busy_ok = 1; stall_ok = 1; hl_ok = 1;
    while (cyc <= W + 4 && done_cyc < 0) begin
      @(negedge clock);
      if (busy !== 1'b1) busy_ok = 0;
      if (hold_mf && stall !== 1'b1) stall_ok = 0;
      if (hi !== exp_hi || lo !== exp_lo) hl_ok = 0;
      if (done === 1'b1) begin
        done_cyc = cyc; dz_seen = div_zero;
      end else begin
        @(posedge clock); #1; cyc++;
      end
    end
    chk("done_cycle", done_cyc, W + 1);
    chk("busy_during_run", busy_ok, 1);
    chk("hilo_held_until_done", hl_ok, 1);
    chk("div_zero", dz_seen, ez);
    if (hold_mf) chk("stall_during_run", stall_ok, 1);
    @(posedge clock); #1;
    exp_hi = eh; exp_lo = el;
    chk($sformatf("hi_f%b_%h_%h", f, x, y), hi, exp_hi);
    chk($sformatf("lo_f%b_%h_%h", f, x, y), lo, exp_lo);
    chk("idle_after", busy, 0);
    chk("done_pulse_end", done, 0);
    if (hold_mf) begin
      chk("mflo_after_done", result, exp_lo);
      chk("mflo_no_stall", stall, 0);
      @(posedge clock); #1;
      start = 1'b0;
    end
  endtask

  task automatic mt(input logic [5:0] f, input logic [31:0] x);
    ula_operation = OPR; func = f; a = x; start = 1'b1;
    @(negedge clock);
    chk("mt_stall", stall, 0);
    @(posedge clock); #1;
    start = 1'b0;
    if (f == MTHI) exp_hi = x; else exp_lo = x;
    chk("mt_hi", hi, exp_hi);
    chk("mt_lo", lo, exp_lo);
    chk("mt_busy", busy, 0);
  endtask

  task automatic mf(input logic [5:0] f);
    ula_operation = OPR; func = f; start = 1'b1;
    @(negedge clock);
    chk("mf_result", result, (f == MFHI) ? exp_hi : exp_lo);
    chk("mf_busy", busy, 0);
    @(posedge clock); #1;
    start = 1'b0;
    chk("mf_hi_kept", hi, exp_hi);
    chk("mf_lo_kept", lo, exp_lo);
  endtask

  initial begin
    logic [5:0] rf;
    logic [31:0] rx, ry;
    bit no_done;
    logic [5:0] flist [4];
    flist[0] = MULT; flist[1] = MULTU; flist[2] = DIV; flist[3] = DIVU;

    clock = 1'b0; reset = 1'b1; start = 1'b0;
    ula_operation = 4'b0000; func = 6'b000000; a = '0; b = '0;
    @(negedge clock);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div_zero", div_zero, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    run_md(MULT, 32'hFFFFFFFD, 32'd5, 0);
    run_md(DIVU, 32'd100, 32'd7, 0);
    run_md(DIV, 32'hFFFFFFF9, 32'd2, 0);
    run_md(DIV, 32'd5, 32'd0, 0);
    run_md(DIV, 32'h80000000, 32'hFFFFFFFF, 0);
    run_md(MULT, 32'd7, 32'd9, 1);

    mt(MTHI, 32'h00001234);
    mf(MFHI);
    mt(MTLO, $urandom);
    mf(MFLO);

    run_md(MULTU, $urandom, $urandom, 0);
    run_md(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);

    for (int i = 0; i < 16; i++) begin
      rf = flist[$urandom_range(0, 3)];
      rx = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0:       ry = 32'd0;
        1:       ry = $urandom_range(1, 15);
        2:       ry = 32'hFFFFFFFF;
        default: ry = $urandom;
      endcase
      run_md(rf, rx, ry, 0);
    end

    // asynchronous reset in the middle of RUN
    ula_operation = OPR; func = MULT; a = $urandom; b = $urandom; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    chk("rst_run_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("rst_run_busy", busy, 0);
    chk("rst_run_hi", hi, 0);
    chk("rst_run_lo", lo, 0);
    chk("rst_run_done", done, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    no_done = 1;
    repeat (W + 4) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0) no_done = 0;
    end
    chk("rst_run_no_done", no_done, 1);
    chk("rst_run_hi_after", hi, 0);
    @(posedge clock); #1;

    // decode sweep
    start = 1'b0;
    for (int op = 0; op < 16; op++) begin
      ula_operation = 4'(op);
      func = 6'($urandom);
      #2;
      chk($sformatf("dec_%h_%b", ula_operation, func), operation, ref_op(ula_operation, func));
    end
    for (int f = 0; f < 64; f++) begin
      ula_operation = OPR;
      func = 6'(f);
      #2;
      chk($sformatf("dec_2_%b", func), operation, ref_op(OPR, func));
    end
    chk("dec_nor", operation, ref_op(OPR, 6'b111111));
    ula_operation = OPR; func = 6'b100111; #2;
    chk("dec_nor_fixed", operation, 4'b1100);
    func = MULT; #2;
    chk("dec_mult_fixed", operation, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
